mtimer: RTL and testbench

- Machine timer that sits directly upstream of the CSR unit and produces its active-low timer-interrupt input `ti`.
- Holds a 64-bit free-running `mtime` counter and a 64-bit `mtimecmp` compare register, both memory-mapped on a simple 32-bit bus.
- Drives `ti` low while `mtime >= mtimecmp`. The CSR unit gates `ti` with `mie[7]` and `mstatus[3]`; software clears the condition by rewriting `mtimecmp`.

---
 rtl/mtimer.sv | 100 ++++++++++
 tb/tb_mtimer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mtimer.sv
// Machine timer: 64-bit free-running mtime with prescaler, 64-bit mtimecmp,
// both on a 32-bit bus, and a registered active-low interrupt for the CSR unit.
module mtimer #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_sel,
   input  logic        bus_we,
   input  logic [3:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        bus_ack,
   output logic        ti
);

   localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic [15:0] presc_q, presc_d;
   logic [31:0] shadow_q, shadow_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ack_q, ack_d;
   logic        ti_q, ti_d;

   logic        wr_en;
   logic        rd_en;
   logic [1:0]  word_sel;
   logic        tick;

   assign wr_en    = bus_sel & bus_we;
   assign rd_en    = bus_sel & ~bus_we;
   assign word_sel = bus_addr[3:2];
   assign tick     = (presc_q == PRESC_MAX);

   always_comb begin
      presc_d    = tick ? 16'd0 : presc_q + 16'd1;
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      shadow_d   = shadow_q;
      rdata_d    = rdata_q;
      ack_d      = bus_sel;
      ti_d       = ~(mtime_q >= mtimecmp_q);

      // A write to either mtime half overrides the increment without carrying into the other half.
      if (wr_en) begin
         unique case (word_sel)
            2'd0: begin
               mtime_d = {mtime_q[63:32], bus_wdata};
               presc_d = 16'd0;
            end
            2'd1: begin
               mtime_d = {bus_wdata, mtime_q[31:0]};
               presc_d = 16'd0;
            end
            2'd2: mtimecmp_d = {mtimecmp_q[63:32], bus_wdata};
            2'd3: mtimecmp_d = {bus_wdata, mtimecmp_q[31:0]};
         endcase
      end

      // Reading the low word latches the high word so a lo-then-hi pair is coherent.
      if (rd_en) begin
         unique case (word_sel)
            2'd0: begin
               rdata_d  = mtime_q[31:0];
               shadow_d = mtime_q[63:32];
            end
            2'd1: rdata_d = shadow_q;
            2'd2: rdata_d = mtimecmp_q[31:0];
            2'd3: rdata_d = mtimecmp_q[63:32];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         presc_q    <= '0;
         shadow_q   <= '0;
         rdata_q    <= '0;
         ack_q      <= 1'b0;
         ti_q       <= 1'b1;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         presc_q    <= presc_d;
         shadow_q   <= shadow_d;
         rdata_q    <= rdata_d;
         ack_q      <= ack_d;
         ti_q       <= ti_d;
      end
   end

   assign bus_rdata = rdata_q;
   assign bus_ack   = ack_q;
   assign ti        = ti_q;

endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: a PRESCALE=1 and a PRESCALE=4 instance share one bus;
// register vectors come from a table, timing corners from directed sequences.
module tb_mtimer;

   logic        clk = 1'b0;
   logic        rst;
   logic        bus_sel;
   logic        bus_we;
   logic [3:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] rdata1, rdata4;
   logic        ack1, ack4;
   logic        ti1, ti4;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic        sel;
      logic        we;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic        exp_ack;
      logic        chk_rdata;
      logic [31:0] exp_rdata;
      logic        exp_ti;
   } vec_t;

   vec_t vecs[10];

   mtimer #(.PRESCALE(1)) dut1 (
      .clk(clk), .rst(rst), .bus_sel(bus_sel), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(rdata1), .bus_ack(ack1), .ti(ti1)
   );

   mtimer #(.PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .bus_sel(bus_sel), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(rdata4), .bus_ack(ack4), .ti(ti4)
   );

   always #5 clk = ~clk;

   // Advance one edge and land on the following falling edge for sampling.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One bus request for exactly one edge, then the bus returns to idle.
   task automatic applyStimulus(input logic sel, input logic we, input logic [3:0] addr,
                                input logic [31:0] wdata);
      bus_sel   = sel;
      bus_we    = we;
      bus_addr  = addr;
      bus_wdata = wdata;
      step();
      bus_sel   = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = 4'h0;
      bus_wdata = 32'h0;
   endtask

   initial begin
      vecs[0] = '{"wr_cmp_hi",      1, 1, 4'hC, 32'h1234_5678, 1, 0, 32'h0,          1};
      vecs[1] = '{"wr_cmp_lo_a9",   1, 1, 4'h9, 32'h9ABC_DEF0, 1, 0, 32'h0,          1};
      vecs[2] = '{"rd_cmp_hi_aF",   1, 0, 4'hF, 32'h0,         1, 1, 32'h1234_5678,  1};
      vecs[3] = '{"rd_cmp_lo_aB",   1, 0, 4'hB, 32'h0,         1, 1, 32'h9ABC_DEF0,  1};
      vecs[4] = '{"wr_mtime_hi",    1, 1, 4'h4, 32'h0,         1, 0, 32'h0,          1};
      vecs[5] = '{"wr_mtime_lo",    1, 1, 4'h0, 32'h0000_0100, 1, 0, 32'h0,          1};
      vecs[6] = '{"rd_mtime_lo",    1, 0, 4'h0, 32'h0,         1, 1, 32'h0000_0100,  1};
      vecs[7] = '{"idle_hold",      0, 0, 4'h0, 32'h0,         0, 1, 32'h0000_0100,  1};
      vecs[8] = '{"rd_shadow",      1, 0, 4'h4, 32'h0,         1, 1, 32'h0,          1};
      vecs[9] = '{"wr_keeps_rdata", 1, 1, 4'h8, 32'h0000_5555, 1, 1, 32'h0,          1};

      rst = 1'b1;
      bus_sel = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 32'h0;
      repeat (3) step();
      checkOutput("reset_ti", {63'd0, ti1}, 64'd1);
      checkOutput("reset_ack", {63'd0, ack1}, 64'd0);
      checkOutput("reset_rdata", {32'd0, rdata1}, 64'd0);
      checkOutput("reset_ti_p4", {63'd0, ti4}, 64'd1);
      rst = 1'b0;

      // Test 1: ten idle cycles at PRESCALE=1, then read the low word.
      for (int i = 1; i <= 10; i++) begin
         step();
         checkOutput($sformatf("idle_ti_%0d", i), {63'd0, ti1}, 64'd1);
         checkOutput($sformatf("idle_ack_%0d", i), {63'd0, ack1}, 64'd0);
      end
      applyStimulus(1, 0, 4'h0, 32'h0);
      checkOutput("t1_ack", {63'd0, ack1}, 64'd1);
      checkOutput("t1_rdata", {32'd0, rdata1}, 64'd10);

      // Back-to-back table vectors on the PRESCALE=1 instance.
      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].sel, vecs[v].we, vecs[v].addr, vecs[v].wdata);
         checkOutput({vecs[v].name, "_ack"}, {63'd0, ack1}, {63'd0, vecs[v].exp_ack});
         checkOutput({vecs[v].name, "_ti"}, {63'd0, ti1}, {63'd0, vecs[v].exp_ti});
         if (vecs[v].chk_rdata)
            checkOutput({vecs[v].name, "_rdata"}, {32'd0, rdata1}, {32'd0, vecs[v].exp_rdata});
      end

      // Test 2: prescaler restarts on an mtime write; second write forces a mid-count reset.
      applyStimulus(1, 1, 4'h0, 32'h0);
      step();
      step();
      applyStimulus(1, 1, 4'h0, 32'h0);
      repeat (12) step();
      applyStimulus(1, 0, 4'h0, 32'h0);
      checkOutput("t2_ack_p4", {63'd0, ack4}, 64'd1);
      checkOutput("t2_rdata_p4", {32'd0, rdata4}, 64'd3);
      checkOutput("t2_rdata_p1", {32'd0, rdata1}, 64'd12);

      // Test 3: compare at 20; a hi write must not bump the low word.
      applyStimulus(1, 1, 4'h0, 32'h0);
      applyStimulus(1, 1, 4'h4, 32'h0);
      applyStimulus(1, 1, 4'hC, 32'h0);
      applyStimulus(1, 1, 4'h8, 32'd20);
      for (int k = 1; k <= 20; k++) begin
         step();
         checkOutput($sformatf("t3_ti_k%0d", k), {63'd0, ti1}, (k >= 19) ? 64'd0 : 64'd1);
      end
      applyStimulus(1, 1, 4'h8, 32'd100);
      checkOutput("t3_ti_after_cmp_wr", {63'd0, ti1}, 64'd0);
      step();
      checkOutput("t3_ti_released", {63'd0, ti1}, 64'd1);

      // Test 4: shadow keeps the high word from the preceding low read across a carry.
      applyStimulus(1, 1, 4'hC, 32'hFFFF_FFFF);
      applyStimulus(1, 1, 4'h8, 32'hFFFF_FFFF);
      applyStimulus(1, 1, 4'h4, 32'h0);
      applyStimulus(1, 1, 4'h0, 32'hFFFF_FFFE);
      applyStimulus(1, 0, 4'h0, 32'h0);
      checkOutput("t4_rd_lo", {32'd0, rdata1}, 64'hFFFF_FFFE);
      repeat (5) step();
      applyStimulus(1, 0, 4'h4, 32'h0);
      checkOutput("t4_rd_shadow", {32'd0, rdata1}, 64'd0);
      applyStimulus(1, 0, 4'h0, 32'h0);
      checkOutput("t4_rd_lo2", {32'd0, rdata1}, 64'd5);
      applyStimulus(1, 0, 4'h4, 32'h0);
      checkOutput("t4_rd_hi2", {32'd0, rdata1}, 64'd1);

      // Test 5: 64-bit wrap against an all-ones compare.
      applyStimulus(1, 1, 4'h4, 32'hFFFF_FFFF);
      checkOutput("t5_ti_q1", {63'd0, ti1}, 64'd1);
      applyStimulus(1, 1, 4'h0, 32'hFFFF_FFFF);
      checkOutput("t5_ti_q2", {63'd0, ti1}, 64'd1);
      step();
      checkOutput("t5_ti_at_max", {63'd0, ti1}, 64'd0);
      applyStimulus(1, 0, 4'h0, 32'h0);
      checkOutput("t5_ti_wrapped", {63'd0, ti1}, 64'd1);
      checkOutput("t5_rd_lo", {32'd0, rdata1}, 64'd0);
      applyStimulus(1, 0, 4'h4, 32'h0);
      checkOutput("t5_rd_hi", {32'd0, rdata1}, 64'd0);

      // Test 6: reset beats a same-cycle write while ti is asserted.
      applyStimulus(1, 1, 4'hC, 32'h0);
      applyStimulus(1, 1, 4'h8, 32'h0);
      step();
      checkOutput("t6_ti_active", {63'd0, ti1}, 64'd0);
      rst = 1'b1;
      applyStimulus(1, 1, 4'h8, 32'h0000_0005);
      rst = 1'b0;
      checkOutput("t6_no_ack", {63'd0, ack1}, 64'd0);
      checkOutput("t6_no_ack_p4", {63'd0, ack4}, 64'd0);
      checkOutput("t6_ti_reset", {63'd0, ti1}, 64'd1);
      checkOutput("t6_rdata_reset", {32'd0, rdata1}, 64'd0);
      applyStimulus(1, 0, 4'h0, 32'h0);
      checkOutput("t6_mtime_zero", {32'd0, rdata1}, 64'd0);
      checkOutput("t6_ti_after", {63'd0, ti1}, 64'd1);
      applyStimulus(1, 0, 4'h8, 32'h0);
      checkOutput("t6_cmp_lo", {32'd0, rdata1}, 64'hFFFF_FFFF);
      applyStimulus(1, 0, 4'hC, 32'h0);
      checkOutput("t6_cmp_hi", {32'd0, rdata1}, 64'hFFFF_FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
